// File: rtl/ae_arith_pkg.sv
// Shared arithmetic definitions for the autoencoder datapath: default sizes,
// the add/sub mode type and the saturation clamp values.
package ae_arith_pkg;

    localparam int DEF_WIDTH          = 16;
    localparam int DEF_SEG_W          = 4;
    localparam int DEF_SEGS_PER_STAGE = 2;
    localparam int SAT_MAX_W          = 64;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

    // Clamp value for a width-bit signed result, zero-extended to SAT_MAX_W;
    // sign=1 gives the most negative value, sign=0 the most positive.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int width, input logic sign);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (width - 1);
        return sign ? msb : (msb - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/cla_segment.sv
// One carry-lookahead segment: flattened sum-of-products carries, plus group
// generate/propagate so the next segment can be chained with a single gate level.
module cla_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             g,
    output logic             p,
    output logic             c_msb
);

    logic [SEG_W-1:0] gen;
    logic [SEG_W-1:0] prop;
    logic [SEG_W-1:0] carry;
    logic             seg_g;
    logic             term;
    logic             term_g;

    assign gen  = a & b;
    assign prop = a ^ b;

    // carry[i] = OR_j (gen[j] & prop[j+1..i-1]) | (cin & prop[0..i-1])
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        seg_g    = 1'b0;
        term     = 1'b0;
        term_g   = 1'b0;
        for (int i = 1; i <= SEG_W; i++) begin
            term_g = 1'b0;
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & prop[k];
                end
                term_g = term_g | term;
            end
            if (i == SEG_W) begin
                seg_g = term_g;
            end else begin
                term = cin;
                for (int k = 0; k < i; k++) begin
                    term = term & prop[k];
                end
                carry[i] = term_g | term;
            end
        end
    end

    assign sum   = prop ^ carry;
    assign g     = seg_g;
    assign p     = &prop;
    assign c_msb = carry[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined two's-complement CLA adder/subtractor with valid/ready flow control.
// Define ADDER_SAT_EN to clamp overflowing results instead of wrapping.
module pipelined_cla_adder
    import ae_arith_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SEG_W          = DEF_SEG_W,
    parameter int SEGS_PER_STAGE = DEF_SEGS_PER_STAGE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int STAGE_W = SEG_W * SEGS_PER_STAGE;
    localparam int STAGES  = WIDTH / STAGE_W;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, ready may depend combinationally on
    // downstream ready so a full pipe still moves one op per cycle.
    op_mode_e op;
    assign op = op_mode_e'(in_sub);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BASE = k * STAGE_W;

        logic [WIDTH-1:0]          a_i;
        logic [WIDTH-1:0]          b_i;
        logic [WIDTH-1:0]          sum_i;
        logic [WIDTH-1:0]          sum_o;
        logic [WIDTH-1:0]          sum_d;
        logic                      c_i;
        logic                      v_i;
        logic                      load;
        logic                      next_load;
        logic [STAGE_W-1:0]        seg_sum;
        logic [SEGS_PER_STAGE:0]   chain;
        logic [SEGS_PER_STAGE-1:0] seg_msb;

        logic                      v_q;
        logic [WIDTH-1:0]          a_q;
        logic [WIDTH-1:0]          b_q;
        logic [WIDTH-1:0]          sum_q;
        logic                      c_q;

        if (k == 0) begin : g_head
            // Subtraction as A + ~B + 1, so in_sub is consumed here and travels
            // with its operands as the pre-inverted B and the carry-in.
            assign v_i   = in_valid;
            assign a_i   = in_a;
            assign b_i   = (op == OP_SUB) ? ~in_b : in_b;
            assign sum_i = '0;
            assign c_i   = (op == OP_SUB);
        end else begin : g_body
            assign v_i   = g_stage[k-1].v_q;
            assign a_i   = g_stage[k-1].a_q;
            assign b_i   = g_stage[k-1].b_q;
            assign sum_i = g_stage[k-1].sum_q;
            assign c_i   = g_stage[k-1].c_q;
        end

        if (k == STAGES - 1) begin : g_last_ready
            assign next_load = out_ready;
        end else begin : g_mid_ready
            assign next_load = g_stage[k+1].load;
        end

        assign load     = !v_q || next_load;
        assign chain[0] = c_i;

        for (genvar j = 0; j < SEGS_PER_STAGE; j++) begin : g_seg
            localparam int LO = BASE + j * SEG_W;
            logic seg_g;
            logic seg_p;

            cla_segment #(
                .SEG_W(SEG_W)
            ) u_seg (
                .a    (a_i[LO +: SEG_W]),
                .b    (b_i[LO +: SEG_W]),
                .cin  (chain[j]),
                .sum  (seg_sum[j*SEG_W +: SEG_W]),
                .g    (seg_g),
                .p    (seg_p),
                .c_msb(seg_msb[j])
            );

            assign chain[j+1] = seg_g | (seg_p & chain[j]);
        end

        always_comb begin
            sum_o                    = sum_i;
            sum_o[BASE +: STAGE_W]   = seg_sum;
        end

        if (k == STAGES - 1) begin : g_tail
            logic ovf;
            logic ovf_q;

            assign ovf = seg_msb[SEGS_PER_STAGE-1] ^ chain[SEGS_PER_STAGE];

`ifdef ADDER_SAT_EN
            // Overflow direction follows A's sign: both operands share it then.
            logic [SAT_MAX_W-1:0] lim;
            assign lim   = sat_limit(WIDTH, a_i[WIDTH-1]);
            assign sum_d = ovf ? lim[WIDTH-1:0] : sum_o;
`else
            assign sum_d = sum_o;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load && v_i) begin
                    ovf_q <= ovf;
                end
            end
        end else begin : g_pass
            assign sum_d = sum_o;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load) begin
                v_q <= v_i;
                if (v_i) begin
                    a_q   <= a_i;
                    b_q   <= b_i;
                    sum_q <= sum_d;
                    c_q   <= chain[SEGS_PER_STAGE];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].load;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (default 16-bit, 2-stage build);
// follows ADDER_SAT_EN for the expected overflow results.
module tb_pipelined_cla_adder;

    localparam int W = 16;

`ifdef ADDER_SAT_EN
    localparam logic [W-1:0] POS_OVF = 16'h7FFF;
    localparam logic [W-1:0] NEG_OVF = 16'h8000;
`else
    localparam logic [W-1:0] POS_OVF = 16'h8000;
    localparam logic [W-1:0] NEG_OVF = 16'h7FFF;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_ovf;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH(W),
        .SEG_W(4),
        .SEGS_PER_STAGE(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    int           n_out = 0;
    bit           saw_full = 0;
    bit           done = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   mon_head;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: widen by two bits, compute exactly, then wrap or clamp.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic signed [W+1:0] ra;
        logic signed [W+1:0] rb;
        logic signed [W+1:0] r;
        logic                ovf;
        ra  = $signed({{2{a[W-1]}}, a});
        rb  = $signed({{2{b[W-1]}}, b});
        r   = sub ? (ra - rb) : (ra + rb);
        ovf = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
`ifdef ADDER_SAT_EN
        if (ovf) return {1'b1, r[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}};
`endif
        return {ovf, r[W-1:0]};
    endfunction

    // Every valid output cycle is compared with the queue head, so a stalled
    // result is re-checked each cycle until it is accepted.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_head = exp_q[0];
                check_eq("out_sum", 32'(out_sum), 32'(mon_head[W-1:0]));
                check_eq("out_ovf", 32'(out_ovf), 32'(mon_head[W]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (rst_n && in_valid && !in_ready) saw_full = 1;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W:0] exp);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_eq("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(exp);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_out;
        int stale;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: out_valid low the cycle after transfer, high the one after.
        send(16'h1234, 16'h0FED, 1'b0, {1'b0, 16'h2221});
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_cycle2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Basic add/sub, overflow and carry across the stage boundary.
        send(16'h0005, 16'h0007, 1'b1, {1'b0, 16'hFFFE});
        send(16'h7FFF, 16'h0001, 1'b0, {1'b1, POS_OVF});
        send(16'h8000, 16'h0001, 1'b1, {1'b1, NEG_OVF});
        send(16'h8000, 16'h8000, 1'b0, {1'b1, NEG_OVF == 16'h8000 ? 16'h8000 : 16'h0000});
        send(16'h0000, 16'h8000, 1'b1, {1'b1, POS_OVF});
        send(16'h7FFF, 16'hFFFF, 1'b1, {1'b1, POS_OVF});
        send(16'h00FF, 16'h0001, 1'b0, {1'b0, 16'h0100});
        send(16'hFFFF, 16'h0001, 1'b0, {1'b0, 16'h0000});
        send(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000});
        send(16'hFFFF, 16'hFFFF, 1'b1, {1'b0, 16'h0000});
        send(16'h8000, 16'h8000, 1'b1, {1'b0, 16'h0000});
        send(16'hC000, 16'hC000, 1'b0, {1'b0, 16'h8000});
        drain();

        // Back-pressure: 8 back-to-back ops, out_ready low for cycles 3..6.
        base_out = n_out;
        saw_full = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(W'(i * 16'h1000 + i), 16'h0101, 1'b0,
                         {1'b0, W'(i * 16'h1000 + i + 16'h0101)});
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 6);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_count", 32'(n_out - base_out), 32'd8);
        check_eq("bp_in_ready_dropped", 32'(saw_full), 32'd1);

        // Reset with two ops stalled in the pipe.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, {1'b0, 16'h3333});
        send(16'h4444, 16'h0004, 1'b1, {1'b0, 16'h4440});
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_out_sum", 32'(out_sum), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_eq("midrst_no_stale", 32'(stale), 32'd0);
        @(posedge clk);
        #1;

        // Randomised flow control against the reference model.
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, model(ra, rb, rs));
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
